// File: rtl/decode.sv
// decode: MIPS ID stage. Splits the IF/ID instruction into fields, generates
// control, reads the 32x32 register file (with write-through bypass from
// write-back), sign-extends the immediate and registers it all into ID/EX.
module decode (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_id_npc,
  input  logic [31:0] if_id_instr,
  input  logic        flush,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_write_reg,
  input  logic [31:0] wb_write_data,
  output logic [1:0]  id_ex_wb,
  output logic [2:0]  id_ex_m,
  output logic [3:0]  id_ex_ex,
  output logic [31:0] id_ex_npc,
  output logic [31:0] id_ex_rd1,
  output logic [31:0] id_ex_rd2,
  output logic [31:0] id_ex_imm,
  output logic [4:0]  id_ex_rt,
  output logic [4:0]  id_ex_rd
);

  // ID/EX latch contents
  typedef struct packed {
    logic [1:0]  wb;   // {RegWrite, MemtoReg}
    logic [2:0]  m;    // {Branch, MemRead, MemWrite}
    logic [3:0]  ex;   // {RegDst, ALUOp[1:0], ALUSrc}
    logic [31:0] npc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } id_ex_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;

  assign opcode = if_id_instr[31:26];
  assign rs     = if_id_instr[25:21];
  assign rt     = if_id_instr[20:16];
  assign rd     = if_id_instr[15:11];
  assign imm    = if_id_instr[15:0];

  logic [1:0] ctl_wb;
  logic [2:0] ctl_m;
  logic [3:0] ctl_ex;

  // Control decode from opcode; unknown opcodes fall through to a NOP
  always_comb begin
    ctl_wb = 2'b00;
    ctl_m  = 3'b000;
    ctl_ex = 4'b0000;
    unique case (opcode)
      OP_RTYPE: begin ctl_wb = 2'b10; ctl_m = 3'b000; ctl_ex = 4'b1100; end
      OP_LW:    begin ctl_wb = 2'b11; ctl_m = 3'b010; ctl_ex = 4'b0001; end
      OP_SW:    begin ctl_wb = 2'b00; ctl_m = 3'b001; ctl_ex = 4'b0001; end
      OP_BEQ:   begin ctl_wb = 2'b00; ctl_m = 3'b100; ctl_ex = 4'b0010; end
      default:  ;
    endcase
  end

  // Register file; entry 0 is never written so it stays zero after reset
  logic [31:0][31:0] rf_q, rf_d;
  logic              wr_en;

  assign wr_en = wb_reg_write && (wb_write_reg != 5'd0);

  // Next register-file state from the write-back port
  always_comb begin
    rf_d = rf_q;
    if (wr_en) rf_d[wb_write_reg] = wb_write_data;
  end

  // Register-file state; reset clears every entry and drops the write
  always_ff @(posedge clk) begin
    if (!rst) rf_q <= '0;
    else      rf_q <= rf_d;
  end

  logic [31:0] rd1, rd2;

  // Read ports: $0 reads zero, same-cycle write-back is forwarded
  always_comb begin
    rd1 = rf_q[rs];
    rd2 = rf_q[rt];
    if (wr_en && (wb_write_reg == rs)) rd1 = wb_write_data;
    if (wr_en && (wb_write_reg == rt)) rd2 = wb_write_data;
    if (rs == 5'd0) rd1 = 32'd0;
    if (rt == 5'd0) rd2 = 32'd0;
  end

  id_ex_t id_ex_q, id_ex_d;

  // Next ID/EX contents; a flush squashes only the control bundles
  always_comb begin
    id_ex_d.wb  = flush ? 2'b00   : ctl_wb;
    id_ex_d.m   = flush ? 3'b000  : ctl_m;
    id_ex_d.ex  = flush ? 4'b0000 : ctl_ex;
    id_ex_d.npc = if_id_npc;
    id_ex_d.rd1 = rd1;
    id_ex_d.rd2 = rd2;
    id_ex_d.imm = {{16{imm[15]}}, imm};
    id_ex_d.rt  = rt;
    id_ex_d.rd  = rd;
  end

  // ID/EX latch; reset takes priority over flush
  always_ff @(posedge clk) begin
    if (!rst) id_ex_q <= '0;
    else      id_ex_q <= id_ex_d;
  end

  assign id_ex_wb  = id_ex_q.wb;
  assign id_ex_m   = id_ex_q.m;
  assign id_ex_ex  = id_ex_q.ex;
  assign id_ex_npc = id_ex_q.npc;
  assign id_ex_rd1 = id_ex_q.rd1;
  assign id_ex_rd2 = id_ex_q.rd2;
  assign id_ex_imm = id_ex_q.imm;
  assign id_ex_rt  = id_ex_q.rt;
  assign id_ex_rd  = id_ex_q.rd;

endmodule

// File: tb/tb_decode.sv
// tb_decode: scoreboard bench for the ID stage. Each driven cycle pushes the
// modelled ID/EX contents; they are popped and compared one edge later.
module tb_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_id_npc, if_id_instr;
  logic        flush, wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic [1:0]  id_ex_wb;
  logic [2:0]  id_ex_m;
  logic [3:0]  id_ex_ex;
  logic [31:0] id_ex_npc, id_ex_rd1, id_ex_rd2, id_ex_imm;
  logic [4:0]  id_ex_rt, id_ex_rd;

  decode dut (
    .clk(clk), .rst(rst), .if_id_npc(if_id_npc), .if_id_instr(if_id_instr),
    .flush(flush), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
    .wb_write_data(wb_write_data), .id_ex_wb(id_ex_wb), .id_ex_m(id_ex_m),
    .id_ex_ex(id_ex_ex), .id_ex_npc(id_ex_npc), .id_ex_rd1(id_ex_rd1),
    .id_ex_rd2(id_ex_rd2), .id_ex_imm(id_ex_imm), .id_ex_rt(id_ex_rt),
    .id_ex_rd(id_ex_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [3:0]  ex;
    logic [31:0] npc, rd1, rd2, imm;
    logic [4:0]  rt, rd;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mdl_rf[32];
  int          n_chk = 0;
  int          n_err = 0;

  // Single comparison point
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  // Control table {wb, m, ex} written straight from the opcode list
  function automatic logic [8:0] ctl(input logic [5:0] op);
    case (op)
      6'b000000: ctl = {2'b10, 3'b000, 4'b1100};
      6'b100011: ctl = {2'b11, 3'b010, 4'b0001};
      6'b101011: ctl = {2'b00, 3'b001, 4'b0001};
      6'b000100: ctl = {2'b00, 3'b100, 4'b0010};
      default:   ctl = 9'd0;
    endcase
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] r, input logic we,
                                        input logic [4:0] wr, input logic [31:0] wd);
    if (r == 5'd0) return 32'd0;
    if (we && wr == r) return wd;
    return mdl_rf[r];
  endfunction

  // Drive one cycle, push expectation, pop and compare after the edge
  task automatic step(input logic r, input logic [31:0] npc, input logic [31:0] instr,
                      input logic fl, input logic we, input logic [4:0] wr,
                      input logic [31:0] wd);
    exp_t e, g;
    logic [8:0] c;
    @(negedge clk);
    rst = r; if_id_npc = npc; if_id_instr = instr; flush = fl;
    wb_reg_write = we; wb_write_reg = wr; wb_write_data = wd;
    c = ctl(instr[31:26]);
    if (!r) begin
      e = '{2'b0, 3'b0, 4'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0};
    end else begin
      e.wb  = fl ? 2'b0 : c[8:7];
      e.m   = fl ? 3'b0 : c[6:4];
      e.ex  = fl ? 4'b0 : c[3:0];
      e.npc = npc;
      e.rd1 = mread(instr[25:21], we, wr, wd);
      e.rd2 = mread(instr[20:16], we, wr, wd);
      e.imm = {{16{instr[15]}}, instr[15:0]};
      e.rt  = instr[20:16];
      e.rd  = instr[15:11];
    end
    sb_q.push_back(e);
    @(posedge clk);
    if (!r) for (int i = 0; i < 32; i++) mdl_rf[i] = 32'd0;
    else if (we && wr != 5'd0) mdl_rf[wr] = wd;
    #1;
    g = sb_q.pop_front();
    chk("wb",  {30'd0, id_ex_wb}, {30'd0, g.wb});
    chk("m",   {29'd0, id_ex_m},  {29'd0, g.m});
    chk("ex",  {28'd0, id_ex_ex}, {28'd0, g.ex});
    chk("npc", id_ex_npc, g.npc);
    chk("rd1", id_ex_rd1, g.rd1);
    chk("rd2", id_ex_rd2, g.rd2);
    chk("imm", id_ex_imm, g.imm);
    chk("rt",  {27'd0, id_ex_rt}, {27'd0, g.rt});
    chk("rd",  {27'd0, id_ex_rd}, {27'd0, g.rd});
  endtask

  localparam logic [31:0] NOP = 32'hFC00_0000;  // unknown opcode

  initial begin
    logic [31:0] ins;
    logic [5:0]  ops[5];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
    for (int i = 0; i < 32; i++) mdl_rf[i] = $urandom;  // unknown until reset

    // Reset with arbitrary inputs and a concurrent write
    step(1'b0, 32'h55, 32'h00A01820, 1'b0, 1'b1, 5'd5, 32'hAAAA5555);
    step(1'b0, 32'h66, 32'h8C22FFFC, 1'b1, 1'b1, 5'd9, 32'h1111);
    chk("rst_wb", {30'd0, id_ex_wb}, 32'd0);
    chk("rst_rd1", id_ex_rd1, 32'd0);
    chk("rst_npc", id_ex_npc, 32'd0);
    // Every register reads zero after reset
    for (int r = 1; r < 32; r += 2) begin
      ins = {6'b0, r[4:0], 5'(r + 1), 16'd0};
      step(1'b1, 32'd1, ins, 1'b0, 1'b0, 5'd0, 32'd0);
      chk("rst_rf_rs", id_ex_rd1, 32'd0);
      chk("rst_rf_rt", id_ex_rd2, 32'd0);
    end

    // Write $5 then decode add $3,$5,$0
    step(1'b1, 32'd2, NOP, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
    chk("nop_ctl", {23'd0, id_ex_wb, id_ex_m, id_ex_ex}, 32'd0);
    step(1'b1, 32'd3, 32'h00A01820, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("add_rd1", id_ex_rd1, 32'hDEADBEEF);
    chk("add_rd2", id_ex_rd2, 32'd0);
    chk("add_rd",  {27'd0, id_ex_rd}, 32'd3);
    chk("add_wb",  {30'd0, id_ex_wb}, 32'h2);
    chk("add_ex",  {28'd0, id_ex_ex}, 32'hC);

    // Bypass: write $7 while decoding rs=7, then write/read $0
    step(1'b1, 32'd4, 32'h00E00820, 1'b0, 1'b1, 5'd7, 32'h12345678);
    chk("byp_rd1", id_ex_rd1, 32'h12345678);
    step(1'b1, 32'd5, 32'h00000000, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF);
    chk("zero_byp", id_ex_rd1, 32'd0);
    step(1'b1, 32'd6, 32'h00000000, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("zero_rd", id_ex_rd2, 32'd0);

    // lw $2,-4($1)
    step(1'b1, 32'd9, 32'h8C22FFFC, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("lw_imm", id_ex_imm, 32'hFFFFFFFC);
    chk("lw_wb",  {30'd0, id_ex_wb}, 32'h3);
    chk("lw_m",   {29'd0, id_ex_m},  32'h2);
    chk("lw_ex",  {28'd0, id_ex_ex}, 32'h1);
    chk("lw_rt",  {27'd0, id_ex_rt}, 32'd2);
    chk("lw_npc", id_ex_npc, 32'd9);

    // Flush on beq, with a write-back in the same cycle
    step(1'b1, 32'd10, 32'h10220003, 1'b1, 1'b1, 5'd9, 32'hCAFEF00D);
    chk("fl_ctl", {23'd0, id_ex_wb, id_ex_m, id_ex_ex}, 32'd0);
    chk("fl_imm", id_ex_imm, 32'd3);
    step(1'b1, 32'd11, 32'h01200000, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("fl_wr", id_ex_rd1, 32'hCAFEF00D);
    // beq unflushed
    step(1'b1, 32'd12, 32'h10220003, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("beq_m", {29'd0, id_ex_m}, 32'h4);

    // Unknown opcode (j)
    step(1'b1, 32'd13, 32'h08000010, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("j_ctl", {23'd0, id_ex_wb, id_ex_m, id_ex_ex}, 32'd0);

    // R-type stream with writes, then mid-run reset
    for (int i = 0; i < 6; i++)
      step(1'b1, 32'(20 + i), 32'h00A93020, 1'b0, 1'b1, 5'(10 + i), $urandom);
    step(1'b0, 32'd30, 32'h014B6020, 1'b0, 1'b1, 5'd20, 32'h77777777);
    chk("mid_rst", {23'd0, id_ex_wb, id_ex_m, id_ex_ex}, 32'd0);
    step(1'b1, 32'd31, 32'h014B6020, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("mid_rf10", id_ex_rd1, 32'd0);
    chk("mid_rf11", id_ex_rd2, 32'd0);
    chk("mid_wb", {30'd0, id_ex_wb}, 32'h2);

    // Random traffic against the model
    for (int i = 0; i < 60; i++) begin
      ins = {ops[$urandom_range(0, 4)], 26'($urandom)};
      step(($urandom_range(0, 19) != 0), $urandom, ins, ($urandom_range(0, 4) == 0),
           $urandom_range(0, 1), 5'($urandom), $urandom);
    end

    if (sb_q.size() != 0) chk("sb_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/decode.md
# decode

Instruction-decode stage of the five-stage MIPS pipeline, sitting between the IF/ID latch outputs of fetch and the execute stage. It decodes the 32-bit instruction into control bundles, reads two operands from a 32x32 register file, sign-extends the immediate, and registers everything into the ID/EX latch. It also owns the register-file write port driven by write-back, and inserts a bubble when a taken branch flushes the pipe.

## Interface
- No parameters. Widths are fixed: 32-bit data, 5-bit register specifiers, 32 registers.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low
- if_id_npc  in  32  incremented PC (PC+1, word address) from the IF/ID latch
- if_id_instr  in  32  instruction from the IF/ID latch
- flush  in  1  taken-branch flush; tied to ex_mem_pc_src
- wb_reg_write  in  1  write-back enable
- wb_write_reg  in  5  write-back destination register
- wb_write_data  in  32  write-back data
- id_ex_wb  out  2  {RegWrite, MemtoReg}
- id_ex_m  out  3  {Branch, MemRead, MemWrite}
- id_ex_ex  out  4  {RegDst, ALUOp[1:0], ALUSrc}
- id_ex_npc  out  32  registered if_id_npc
- id_ex_rd1, id_ex_rd2  out  32  register-file data for rs and rt
- id_ex_imm  out  32  sign-extended instr[15:0]
- id_ex_rt, id_ex_rd  out  5  instr[20:16] and instr[15:11]

## Operation
- Field split: opcode = instr[31:26], rs = [25:21], rt = [20:16], rd = [15:11], imm = [15:0].
- Control decode is combinational from the opcode. Each entry lists RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp:
  - 000000 (R-type): 1,0,0,1,0,0,0,10
  - 100011 (lw): 0,1,1,1,1,0,0,00
  - 101011 (sw): 0,1,0,0,0,1,0,00
  - 000100 (beq): 0,0,0,0,0,0,1,01
  - Any other opcode: all controls 0, which is a NOP.
- Register file: 32 x 32 bits, two combinational read ports (rs, rt) and one synchronous write port.
  - A write occurs on a rising edge when wb_reg_write=1, wb_write_reg != 0 and rst=1.
  - Register $0 always reads 0. Writes to $0 are discarded.
- Write-through bypass: if a read specifier equals wb_write_reg, is nonzero, and wb_reg_write=1 in the same cycle, that read port returns wb_write_data rather than the stored value.
- Sign extension: imm32 = {{16{imm[15]}}, imm}.
- ID/EX latch: on every rising edge all id_ex_* outputs load the decoded, read and extended values.
- Priority at each edge: rst=0, then flush=1, then normal load.
  - flush=1: id_ex_wb, id_ex_m and id_ex_ex load 0 (bubble). The data fields still load normally.
  - Write-back is unaffected by flush.

## Timing
- Latency is one cycle from if_id_* to id_ex_*. There are no stalls and no handshake; a new instruction is accepted every cycle.
- Reset (rst=0 sampled at an edge):
  - Every id_ex_* output becomes 0.
  - All 32 registers become 0 in that same edge.
  - Any concurrent write-back is dropped.
  - Reset asserted mid-stream discards the in-flight decode. The first valid ID/EX output appears one edge after rst returns to 1.
- A write at edge N is visible to a read decoded in cycle N+1 from the array. A read in cycle N gets it through the bypass.
- Flush and write-back in the same cycle: the write completes and the bubble is inserted.
- The all-zero instruction (sll $0,$0,0) decodes as R-type with rd=$0. It is harmless because writes to $0 are discarded.

## Test plan
- Reset: hold rst=0 for 2 edges with arbitrary inputs -> all id_ex_* = 0. Afterwards, reading any register returns 0.
- Write then read: write $5=0xDEADBEEF at edge 1, then decode add $3,$5,$0 (0x00A01820) -> id_ex_rd1=0xDEADBEEF, id_ex_rd2=0, id_ex_rd=3, id_ex_wb=2'b10, id_ex_ex=4'b1100.
- Bypass and $0: in the same cycle, write $7=0x12345678 and decode an instruction with rs=7 -> id_ex_rd1=0x12345678. Then write $0=0xFFFFFFFF and read $0 -> 0.
- lw with negative offset: lw $2,-4($1) (0x8C22FFFC), if_id_npc=9 -> id_ex_imm=0xFFFFFFFC, id_ex_wb=2'b11, id_ex_m=3'b010, id_ex_ex=4'b0001, id_ex_rt=2, id_ex_npc=9.
- Flush: beq $1,$2,+3 (0x10220003) with flush=1 -> id_ex_wb=0, id_ex_m=0, id_ex_ex=0, id_ex_imm=3.
- Unknown opcode and mid-run reset: j 0x08000010 -> all controls 0. Assert rst=0 during a stream of R-types -> outputs zero on the next edge and the register file is cleared.
